// File: rtl/mem_arbiter2.sv
// Two-port round-robin arbiter/sequencer in front of a single 256x8 data memory port.
// Ownership is registered; bursts are bounded to MAX_BURST beats while the other side waits.
module mem_arbiter2 #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  function automatic logic [1:0] own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ptr_reg, ptr_next;

  logic              req   [2];
  logic              we    [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  assign req[0]   = Req0;
  assign req[1]   = Req1;
  assign we[0]    = We0;
  assign we[1]    = We1;
  assign addr[0]  = Addr0;
  assign addr[1]  = Addr1;
  assign wdata[0] = WData0;
  assign wdata[1] = WData1;

  // owner is only meaningful while owned is high; the unused encoding 2'b11 behaves as IDLE
  logic owned, owner, other_req, grant_port;
  assign owned     = (state_reg == OWN0) || (state_reg == OWN1);
  assign owner     = (state_reg == OWN1);
  assign other_req = req[!owner];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    grant_port = 1'b0;
    if (!owned) begin
      state_next = IDLE;
      if (req[0] || req[1]) begin
        grant_port = (req[0] && req[1]) ? ptr_reg : req[1];
        state_next = own_state(grant_port);
        ptr_next   = !grant_port;
        cnt_next   = '0;
      end
    end else if (!req[owner]) begin
      // Owner went quiet: hand over this cycle, memory sits idle
      cnt_next = '0;
      if (other_req) begin
        state_next = own_state(!owner);
        ptr_next   = owner;
      end else begin
        state_next = IDLE;
      end
    end else if (cnt_reg == CNT_LAST) begin
      // Burst window exhausted: yield only if the other side is waiting
      cnt_next = '0;
      if (other_req) begin
        state_next = own_state(!owner);
        ptr_next   = owner;
      end
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign Gnt0 = (state_reg == OWN0);
  assign Gnt1 = (state_reg == OWN1);

  // Memory strobes decode straight from state so an async reset kills a write in flight
  always_comb begin
    MemAddress   = '0;
    MemWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    if (owned) begin
      MemAddress   = addr[owner];
      MemWriteData = wdata[owner];
      MemWrite     = req[owner] & we[owner];
      MemRead      = req[owner] & ~we[owner];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              read_beat;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    assign read_beat = (state_reg == own_state(1'(gi))) & req[gi] & ~we[gi];

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= read_beat;
        if (read_beat) begin
          rdata_reg <= MemReadData;
        end
      end
    end
  end

  assign RValid0 = g_port[0].rvalid_reg;
  assign RValid1 = g_port[1].rvalid_reg;
  assign RData0  = g_port[0].rdata_reg;
  assign RData1  = g_port[1].rdata_reg;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: attached 256x8 memory, an ownership/burst model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter2;

  localparam int MAX_BURST = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       req_s  [2];
  logic       we_s   [2];
  logic [7:0] addr_s [2];
  logic [7:0] wd_s   [2];

  logic       Gnt0, Gnt1, RValid0, RValid1, MemWrite, MemRead;
  logic [7:0] RData0, RData1, MemAddress, MemWriteData, MemReadData;

  logic [7:0] env_mem [256];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int beats0[$];
  int beats1[$];

  // Model state: owner -1 = nobody, used = beats taken in the current window
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_used  = 0;
  logic [7:0] m_mem [256];
  logic       m_rv  [2];
  logic [7:0] m_rd  [2];

  mem_arbiter2 #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(req_s[0]), .Req1(req_s[1]), .We0(we_s[0]), .We1(we_s[1]),
    .Addr0(addr_s[0]), .Addr1(addr_s[1]), .WData0(wd_s[0]), .WData1(wd_s[1]),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RData0(RData0), .RData1(RData1),
    .RValid0(RValid0), .RValid1(RValid1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  assign MemReadData = MemRead ? env_mem[MemAddress] : 8'h00;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (MemWrite) env_mem[MemAddress] <= MemWriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge Clk) begin : model
    int o;
    if (!Rst_n) begin
      m_owner = -1; m_ptr = 0; m_used = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    end
    o = m_owner;
    chk("gnt0", Gnt0, (o == 0));
    chk("gnt1", Gnt1, (o == 1));
    if (o >= 0) begin
      chk("mem_addr", MemAddress, addr_s[o]);
      chk("mem_wdata", MemWriteData, wd_s[o]);
      chk("mem_write", MemWrite, req_s[o] && we_s[o]);
      chk("mem_read", MemRead, req_s[o] && !we_s[o]);
    end else begin
      chk("mem_addr_idle", MemAddress, 8'h00);
      chk("mem_wdata_idle", MemWriteData, 8'h00);
      chk("mem_write_idle", MemWrite, 1'b0);
      chk("mem_read_idle", MemRead, 1'b0);
    end
    chk("rvalid0", RValid0, m_rv[0]);
    chk("rvalid1", RValid1, m_rv[1]);
    chk("rdata0", RData0, m_rd[0]);
    chk("rdata1", RData1, m_rd[1]);
    if (Gnt0 && req_s[0]) beats0.push_back(cyc);
    if (Gnt1 && req_s[1]) beats1.push_back(cyc);

    if (Rst_n) begin
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (o >= 0 && req_s[o]) begin
        if (we_s[o]) m_mem[addr_s[o]] = wd_s[o];
        else begin m_rd[o] = m_mem[addr_s[o]]; m_rv[o] = 1'b1; end
        m_used++;
        if (m_used == MAX_BURST) begin
          m_used = 0;
          if (req_s[1-o]) begin m_owner = 1 - o; m_ptr = o; end
        end
      end else if (o >= 0) begin
        m_used = 0;
        if (req_s[1-o]) begin m_owner = 1 - o; m_ptr = o; end
        else m_owner = -1;
      end else if (req_s[0] || req_s[1]) begin
        m_owner = (req_s[0] && req_s[1]) ? m_ptr : (req_s[0] ? 0 : 1);
        m_ptr   = 1 - m_owner;
        m_used  = 0;
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Present one beat and hold it until the grant is seen at a closing edge
  task automatic beat(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    req_s[p] = 1'b1; we_s[p] = w; addr_s[p] = a; wd_s[p] = d;
    forever begin
      @(negedge Clk);
      if ((p == 0 ? Gnt0 : Gnt1) === 1'b1) break;
      t++;
      if (t > 40) begin
        total++;
        $display("FAIL beat_timeout port %0d: got no grant, required grant within 40 cycles", p);
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_port(input int p);
    req_s[p] = 1'b0; we_s[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin env_mem[i] = 8'h00; m_mem[i] = 8'h00; end
    for (int p = 0; p < 2; p++) begin
      req_s[p] = 1'b0; we_s[p] = 1'b0; addr_s[p] = 8'h00; wd_s[p] = 8'h00;
    end
    settle(2);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("reset_gnt0", Gnt0, 1'b0);
    chk("reset_rdata0", RData0, 8'h00);
    settle(1);

    // Write then read back on port 0
    beat(0, 1'b1, 8'h10, 8'hA5);
    beat(0, 1'b0, 8'h10, 8'h00);
    idle_port(0);
    @(negedge Clk);
    chk("t1_rvalid0", RValid0, 1'b1);
    chk("t1_rdata0", RData0, 8'hA5);
    chk("t1_rdata1", RData1, 8'h00);
    settle(2);

    // Tie from reset: port 0 first, one idle cycle on release
    Rst_n = 1'b0;
    settle(1);
    Rst_n = 1'b1;
    beats0.delete(); beats1.delete();
    fork
      begin beat(0, 1'b0, 8'h10, 8'h00); beat(0, 1'b0, 8'h11, 8'h00); idle_port(0); end
      begin beat(1, 1'b0, 8'h12, 8'h00); idle_port(1); end
    join
    settle(2);
    chk("t2_port0_first", beats0[0] < beats1[0], 1'b1);
    chk("t2_release_gap", beats1[0] - beats0[1], 2);

    beats0.delete(); beats1.delete();
    fork
      begin beat(0, 1'b0, 8'h10, 8'h00); idle_port(0); end
      begin beat(1, 1'b0, 8'h10, 8'h00); idle_port(1); end
    join
    settle(2);
    chk("t2_next_tie_port0", beats0[0] < beats1[0], 1'b1);

    // Continuous contention: 4-beat windows alternating with no gap
    beats0.delete(); beats1.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) beat(0, 1'b1, 8'(8'h50 + i), 8'(8'h60 + i));
        idle_port(0);
      end
      begin
        for (int i = 0; i < 8; i++) beat(1, 1'b1, 8'(8'h70 + i), 8'(8'h80 + i));
        idle_port(1);
      end
    join
    settle(2);
    chk("t3_beats0", beats0.size(), 8);
    chk("t3_beats1", beats1.size(), 8);
    chk("t3_window0_len", beats0[3] - beats0[0], 3);
    chk("t3_switch_0to1", beats1[0] - beats0[3], 1);
    chk("t3_switch_1to0", beats0[4] - beats1[3], 1);
    chk("t3_switch_0to1b", beats1[4] - beats0[7], 1);

    // Port 0 alone for 10 beats keeps the grant across the window wrap
    beats0.delete(); beats1.delete();
    for (int i = 0; i < 10; i++) beat(0, 1'b0, 8'(8'h50 + (i % 8)), 8'h00);
    idle_port(0);
    @(negedge Clk);
    chk("t4_last_rdata0", RData0, 8'h61);
    settle(1);
    chk("t4_beats0", beats0.size(), 10);
    chk("t4_contiguous", beats0[9] - beats0[0], 9);

    // Reset lands during a write beat to 0x20
    beat(0, 1'b1, 8'h21, 8'h77);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 8'h20; wd_s[0] = 8'h99;
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    chk("t5_gnt0_cleared", Gnt0, 1'b0);
    chk("t5_memwrite_off", MemWrite, 1'b0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    idle_port(0);
    settle(1);
    beat(0, 1'b0, 8'h21, 8'h00);
    idle_port(0);
    @(negedge Clk);
    chk("t5_rdata_0x21", RData0, 8'h77);
    settle(1);
    beat(0, 1'b0, 8'h20, 8'h00);
    idle_port(0);
    @(negedge Clk);
    chk("t5_rvalid_0x20", RValid0, 1'b1);
    chk("t5_rdata_0x20", RData0, 8'h00);
    settle(1);

    // Cross-port visibility
    beat(1, 1'b1, 8'h40, 8'h33);
    idle_port(1);
    beat(0, 1'b0, 8'h40, 8'h00);
    idle_port(0);
    @(negedge Clk);
    chk("t6_rdata0", RData0, 8'h33);
    chk("t6_rvalid1", RValid1, 1'b0);
    settle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-port arbiter and sequencer for the shared 8-bit data memory (256 × 8, synchronous write, combinational read gated by MemRead). It sits between two requesters (e.g. the datapath load/store unit and a fill/DMA engine) and the single memory port, granting ownership round-robin with a bounded burst length. It drives the memory's Address/WriteData/MemWrite/MemRead and returns registered read data with a valid strobe to the owning requester.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_BURST, 4, maximum consecutive beats one owner keeps while the other requests (≥1)

Ports:
- Clk  in  1  single clock; all state updates on posedge
- Rst_n  in  1  asynchronous, active-low reset
- Req0, Req1  in  1  beat request from requester 0 / 1
- We0, We1  in  1  1 = write beat, 0 = read beat
- Addr0, Addr1  in  ADDR_W  beat address
- WData0, WData1  in  DATA_W  write data
- Gnt0, Gnt1  out  1  registered ownership; at most one high
- RData0, RData1  out  DATA_W  captured read data, held until next read beat of that port
- RValid0, RValid1  out  1  one-cycle strobe: RDataN updated this cycle
- MemAddress  out  ADDR_W  to memory Address
- MemWriteData  out  DATA_W  to memory WriteData
- MemWrite, MemRead  out  1  to memory strobes
- MemReadData  in  DATA_W  from memory ReadData

## Operation
- State: IDLE, OWN0, OWN1; beat counter cnt (0..MAX_BURST-1); priority pointer ptr (0 or 1).
- Gnt0 = (state==OWN0), Gnt1 = (state==OWN1), both registered.
- Beat on port N = GntN & ReqN in a cycle; committed at the closing posedge.
- Memory mux (combinational from state): in OWNN, MemAddress=AddrN, MemWriteData=WDataN, MemWrite=ReqN&WeN, MemRead=ReqN&~WeN. In IDLE: all memory outputs 0.
- Read beat on N: at closing edge, RDataN <= MemReadData and RValidN <= 1; otherwise RValidN <= 0. The other port's RData is unchanged.
- IDLE: only one Req high → OWN that port. Both high → OWN ptr. None → stay. On any grant, cnt <= 0 and ptr <= the opposite of the granted port.
- OWNN, ReqN=0 → release: OWN other if its Req is high (ptr <= N, cnt <= 0), else IDLE. No memory access in this cycle.
- OWNN, beat, cnt==MAX_BURST-1, other Req high → forced release to OWN other (cnt <= 0, ptr <= N).
- OWNN, beat, cnt==MAX_BURST-1, other Req low → stay, cnt <= 0 (new window).
- OWNN, beat otherwise → stay, cnt <= cnt+1.
- Requester protocol: hold Req with We/Addr/WData valid until a beat is seen (GntN high at the edge); present the next beat, or drop Req, in the following cycle.

## Timing
- Reset (Rst_n low, async): state IDLE, cnt 0, ptr 0 (port 0 wins first tie), Gnt0/1=0, RValid0/1=0, RData0/1=0. Memory strobes go 0 immediately, so a write in flight is suppressed; memory contents are not cleared.
- Latency from Req rise in IDLE: Gnt high next cycle; first beat commits at the edge ending that cycle; read data/RValid visible in the cycle after the beat.
- Sustained throughput: 1 beat/cycle within a burst. A switch via release-on-Req-low costs one idle memory cycle; a forced switch after MAX_BURST costs none.
- Write then read of the same address by any port in consecutive beats returns the new data (write commits at edge, combinational read next cycle).
- Simultaneous Req rise on both ports in IDLE: only the ptr port is granted; the other waits with Req held.

## Test plan
- Reset, then Req0 write Addr0=0x10, WData0=0xA5 → Gnt0 next cycle, MemWrite=1 for one cycle; then Req0 read 0x10 → RValid0 pulse, RData0=0xA5, RData1 stays 0.
- Both Req rise together from reset → Gnt0 first; after Req0 drops, one idle cycle, then Gnt1; next tie → Gnt0 (ptr alternates).
- MAX_BURST=4, both requesting continuously → exactly 4 beats on port 0, Gnt1 on the next cycle with no gap, 4 beats on port 1, and so on; Gnt0&Gnt1 never high together.
- Port 0 alone requesting for 10 beats → Gnt0 held throughout, cnt wraps, no deassertion.
- Rst_n pulsed low mid-burst during a write beat to 0x20 (old value 0x00) → Gnt/RValid clear immediately, MemWrite 0, and a later read of 0x20 returns 0x00.
- Port 1 writes 0x33→0x40; port 0 reads 0x40 on its next grant → RData0=0x33.
